// File: rtl/systolic_sched_if.sv
// Handshake and control bundle between the tile feeders, the result consumer,
// the systolic_array controls and the systolic_sched sequencer.
interface systolic_sched_if #(
  parameter int N_ROWS = 2,
  parameter int KW     = 16
);
  logic              start;
  logic [KW-1:0]     k_len;
  logic [N_ROWS-1:0] row_mask;
  logic              w_valid;
  logic              w_ready;
  logic              a_valid;
  logic              a_ready;
  logic              a_zero;
  logic              arr_en;
  logic              arr_clr;
  logic              arr_load_weight;
  logic [N_ROWS-1:0] arr_row_en;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic [31:0]       busy_cycles;

  // Upstream side: DMA/buffer logic, result consumer and array observer
  modport master (
    output start, k_len, row_mask, w_valid, a_valid, res_ready,
    input  w_ready, a_ready, a_zero, arr_en, arr_clr, arr_load_weight,
           arr_row_en, res_valid, busy, done, busy_cycles
  );

  // Sequencer side
  modport slave (
    input  start, k_len, row_mask, w_valid, a_valid, res_ready,
    output w_ready, a_ready, a_zero, arr_en, arr_clr, arr_load_weight,
           arr_row_en, res_valid, busy, done, busy_cycles
  );
endinterface

// File: rtl/systolic_sched.sv
// Cycle-level sequencer for the row-stationary systolic array.
// A tile runs CLEAR -> LOAD_W -> STREAM (k_len beats) -> DRAIN (N_COLS+PIPE)
// -> RESULT. Array controls are decoded from the registered state so that a
// bubble on a_valid stalls the whole array in the same cycle.
module systolic_sched #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int PIPE   = 1,
  parameter int KW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  systolic_sched_if.slave bus
);

  localparam int D  = N_COLS + PIPE;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_W = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t            state_q;
  logic [KW-1:0]     beat_cnt_q;
  logic [KW-1:0]     k_len_q;
  logic [DW-1:0]     drain_cnt_q;
  logic [N_ROWS-1:0] mask_q;
  logic [31:0]       busy_cycles_q;

  // Tile sequencing FSM with its beat/drain counters and busy-cycle meter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= {KW{1'b0}};
      k_len_q       <= {KW{1'b0}};
      drain_cnt_q   <= {DW{1'b0}};
      mask_q        <= {N_ROWS{1'b0}};
      busy_cycles_q <= 32'd0;
    end else begin
      if ((state_q != S_IDLE) && (busy_cycles_q != 32'hFFFF_FFFF)) begin
        busy_cycles_q <= busy_cycles_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          // The accepting cycle is counted as the first cycle of the operation.
          if (bus.start && (bus.k_len != {KW{1'b0}})) begin
            k_len_q       <= bus.k_len;
            mask_q        <= bus.row_mask;
            busy_cycles_q <= 32'd1;
            state_q       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_q <= S_LOAD_W;
        end
        S_LOAD_W: begin
          if (bus.w_valid) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.a_valid) begin
            // k_len_q is never 0 here, so the subtraction cannot wrap.
            if (beat_cnt_q == (k_len_q - {{(KW-1){1'b0}}, 1'b1})) begin
              beat_cnt_q <= {KW{1'b0}};
              state_q    <= S_DRAIN;
            end else begin
              beat_cnt_q <= beat_cnt_q + {{(KW-1){1'b0}}, 1'b1};
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DW'(D - 1)) begin
            drain_cnt_q <= {DW{1'b0}};
            state_q     <= S_RESULT;
          end else begin
            drain_cnt_q <= drain_cnt_q + {{(DW-1){1'b0}}, 1'b1};
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Decode array controls and handshakes from state; everything is 0 in reset
  always_comb begin
    bus.w_ready         = 1'b0;
    bus.a_ready         = 1'b0;
    bus.a_zero          = 1'b0;
    bus.arr_en          = 1'b0;
    bus.arr_clr         = 1'b0;
    bus.arr_load_weight = 1'b0;
    bus.arr_row_en      = {N_ROWS{1'b0}};
    bus.res_valid       = 1'b0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.busy_cycles     = 32'd0;
    if (rst) begin
      bus.busy_cycles = 32'd0;
    end else begin
      bus.busy_cycles = busy_cycles_q;
      bus.busy        = (state_q != S_IDLE);
      bus.arr_row_en  = (state_q != S_IDLE) ? mask_q : {N_ROWS{1'b0}};
      case (state_q)
        S_IDLE: begin
          bus.busy = 1'b0;
        end
        S_CLEAR: begin
          bus.arr_clr = 1'b1;
          bus.arr_en  = 1'b1;
        end
        S_LOAD_W: begin
          bus.w_ready         = 1'b1;
          bus.arr_load_weight = bus.w_valid;
          bus.arr_en          = bus.w_valid;
        end
        S_STREAM: begin
          bus.a_ready = 1'b1;
          bus.arr_en  = bus.a_valid;
        end
        S_DRAIN: begin
          bus.arr_en = 1'b1;
          bus.a_zero = 1'b1;
        end
        S_RESULT: begin
          // res_ready only reaches done, never the upstream readies.
          bus.res_valid = 1'b1;
          bus.done      = bus.res_ready;
        end
        default: begin
          bus.busy = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench for systolic_sched. Each tile is described as an
// expected per-cycle schedule built from the operation rules (clear, weight
// wait/load, bubbles and beats, drain, result wait/handshake); the bench
// drives the schedule's inputs and compares every decoded output against it.
module tb_systolic_sched;

  localparam int N_ROWS = 2;
  localparam int N_COLS = 2;
  localparam int PIPE   = 1;
  localparam int KW     = 16;
  localparam int D      = N_COLS + PIPE;

  logic clk;
  logic rst;

  systolic_sched_if #(.N_ROWS(N_ROWS), .KW(KW)) bus ();

  systolic_sched #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .PIPE(PIPE), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic wv, av, rr;
    logic en, clr, lw, az, wr, ar, rv, dn;
  } rec_t;

  rec_t        sched[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_bc  = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.arr_en, bus.arr_clr, bus.arr_load_weight, bus.a_zero, bus.w_ready,
            bus.a_ready, bus.res_valid, bus.done, bus.busy, bus.arr_row_en};
  endfunction

  // bub_mode: 0 no bubbles, 1 one bubble before every odd beat, 2 random 0..2
  task automatic build(input int k, input int wstall, input int bub_mode, input int rwait);
    rec_t r;
    int   nb;
    sched.delete();
    r = '0; r.wv = 1'($urandom); r.av = 1'($urandom); r.rr = 1'($urandom);
    r.en = 1'b1; r.clr = 1'b1;
    sched.push_back(r);
    for (int i = 0; i < wstall; i++) begin
      r = '0; r.av = 1'($urandom); r.rr = 1'($urandom); r.wr = 1'b1;
      sched.push_back(r);
    end
    r = '0; r.wv = 1'b1; r.av = 1'($urandom); r.rr = 1'($urandom);
    r.wr = 1'b1; r.lw = 1'b1; r.en = 1'b1;
    sched.push_back(r);
    for (int b = 0; b < k; b++) begin
      nb = (bub_mode == 1) ? (b % 2) : ((bub_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int j = 0; j < nb; j++) begin
        r = '0; r.wv = 1'($urandom); r.rr = 1'($urandom); r.ar = 1'b1;
        sched.push_back(r);
      end
      r = '0; r.wv = 1'($urandom); r.rr = 1'($urandom); r.av = 1'b1; r.ar = 1'b1; r.en = 1'b1;
      sched.push_back(r);
    end
    for (int j = 0; j < D; j++) begin
      r = '0; r.wv = 1'($urandom); r.av = 1'($urandom); r.rr = 1'($urandom);
      r.en = 1'b1; r.az = 1'b1;
      sched.push_back(r);
    end
    for (int j = 0; j < rwait; j++) begin
      r = '0; r.wv = 1'($urandom); r.av = 1'($urandom); r.rv = 1'b1;
      sched.push_back(r);
    end
    r = '0; r.wv = 1'($urandom); r.av = 1'($urandom); r.rr = 1'b1; r.rv = 1'b1; r.dn = 1'b1;
    sched.push_back(r);
  endtask

  // Runs one tile against the current schedule; abort_at >= 0 asserts rst there
  task automatic run(input int k, input logic [1:0] mask, input int abort_at, input bit junk);
    int          beats;
    rec_t        r;
    logic [10:0] ex;
    beats = 0;
    bus.start     = 1'b1;
    bus.k_len     = KW'(k);
    bus.row_mask  = mask;
    bus.w_valid   = 1'($urandom);
    bus.a_valid   = 1'($urandom);
    bus.res_ready = 1'($urandom);
    @(negedge clk);
    chk("idle_outs", 64'({outs(), bus.busy_cycles}), 64'({11'd0, last_bc}));
    @(posedge clk); #1;
    foreach (sched[i]) begin
      r = sched[i];
      if (junk) begin
        bus.start    = 1'($urandom);
        bus.k_len    = KW'($urandom);
        bus.row_mask = 2'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      bus.w_valid   = r.wv;
      bus.a_valid   = r.av;
      bus.res_ready = r.rr;
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", 64'({outs(), bus.busy_cycles}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      ex = {r.en, r.clr, r.lw, r.az, r.wr, r.ar, r.rv, r.dn, 1'b1, mask};
      @(negedge clk);
      chk($sformatf("cyc%0d", i), 64'(outs()), 64'(ex));
      if (bus.a_valid && bus.a_ready) beats++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("post_idle", 64'({bus.busy, bus.done, bus.res_valid}), 64'd0);
    if (abort_at < 0) begin
      chk("beats", 64'(beats), 64'(k));
      last_bc = 32'(sched.size() + 1);
      chk("busy_cycles", 64'(bus.busy_cycles), 64'(last_bc));
    end else begin
      last_bc = 32'd0;
      chk("abort_bc", 64'(bus.busy_cycles), 64'(last_bc));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          k;
    logic [1:0]  m;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.row_mask  = '0;
    bus.w_valid   = 1'b1;
    bus.a_valid   = 1'b1;
    bus.res_ready = 1'b1;

    // Reset: everything forced low, then IDLE with a cleared meter
    @(negedge clk);
    chk("rst_outs", 64'({outs(), bus.busy_cycles}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", 64'({outs(), bus.busy_cycles}), 64'd0);
    @(posedge clk); #1;

    // start with k_len == 0 is ignored
    bus.start = 1'b1;
    bus.k_len = '0;
    bus.row_mask = 2'b11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("zero_klen_busy", 64'({bus.busy, bus.arr_en, bus.arr_clr}), 64'd0);
    @(posedge clk); #1;

    // Basic run: k_len=4, no stalls, 2+4+3+1 busy cycles plus the accept cycle
    build(4, 0, 0, 0);
    run(4, 2'b11, -1, 1'b0);
    chk("basic_bc_11", 64'(last_bc), 64'd11);

    // Stalls: two weight-wait cycles plus two activation bubbles
    build(4, 2, 1, 0);
    run(4, 2'b11, -1, 1'b0);
    chk("stall_bc_15", 64'(last_bc), 64'd15);

    // Starts with fresh k_len/mask pulsed while busy must not disturb the tile
    build(4, 0, 2, 1);
    run(4, 2'b10, -1, 1'b1);

    // Result backpressure for 5 cycles
    build(3, 0, 0, 5);
    run(3, 2'b11, -1, 1'b0);

    // Reset in the second drain cycle, then a clean run with mask 01
    build(4, 0, 0, 0);
    run(4, 2'b11, 7, 1'b0);
    build(2, 0, 0, 0);
    run(2, 2'b01, -1, 1'b0);

    // k_len=1 edge case
    build(1, 1, 0, 0);
    run(1, 2'b11, -1, 1'b0);

    // Randomized tiles
    for (int it = 0; it < 25; it++) begin
      k = int'($urandom_range(1, 8));
      m = 2'($urandom);
      build(k, int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)));
      run(k, m, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
